adder_share_arbiter: RTL

- Time-multiplexes the single 32-bit ripple/CLA adder instance between NUM_REQ requesters: PC increment, branch-target compute, and ALU add.
- Round-robin arbitration, registered operand launch to the adder, registered result return.
- The adder stays an external instance. This block drives its A/B inputs and samples its SUM/C outputs.
- One operation completes every 2 cycles at full load.

---
 rtl/adder_share_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter that time-shares one external WIDTH-bit adder between
// NUM_REQ requesters: operands are registered at grant, and the result is registered one cycle later.
module adder_share_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_REQ = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   op_a,
  input  logic [NUM_REQ*WIDTH-1:0]   op_b,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [WIDTH-1:0]           rsp_sum,
  output logic                       rsp_carry,
  output logic                       busy,
  output logic [WIDTH-1:0]           add_a,
  output logic [WIDTH-1:0]           add_b,
  input  logic [WIDTH-1:0]           add_sum,
  input  logic                       add_c
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  typedef enum logic {IDLE, EXEC} state_e;

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]     owner_q, owner_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]     rsp_sum_q, rsp_sum_d;
  logic                 rsp_carry_q, rsp_carry_d;
  logic [WIDTH-1:0]     add_a_q, add_a_d;
  logic [WIDTH-1:0]     add_b_q, add_b_d;

  logic [PTR_W-1:0]     hi_idx, lo_idx, win;
  logic                 hi_found, lo_found;
  logic [WIDTH-1:0]     win_a, win_b;

  // Two passes give the wrap-around search: first set bit at or above
  // rr_ptr, otherwise the first set bit overall.
  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!hi_found && req[j] && (PTR_W'(j) >= rr_ptr_q)) begin
        hi_found = 1'b1;
        hi_idx   = PTR_W'(j);
      end
      if (!lo_found && req[j]) begin
        lo_found = 1'b1;
        lo_idx   = PTR_W'(j);
      end
    end
    win = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    win_a = '0;
    win_b = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (PTR_W'(j) == win) begin
        win_a = op_a[j*WIDTH +: WIDTH];
        win_b = op_b[j*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_sum_d   = rsp_sum_q;
    rsp_carry_d = rsp_carry_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          add_a_d  = win_a;
          add_b_d  = win_b;
          owner_d  = win;
          gnt_d    = NUM_REQ'(1) << win;
          rr_ptr_d = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        rsp_sum_d   = add_sum;
        rsp_carry_d = add_c;
        rsp_valid_d = NUM_REQ'(1) << owner_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_carry_q <= rsp_carry_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_carry = rsp_carry_q;
  assign busy      = (state_q == EXEC);
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;

endmodule
